// File: rtl/guess_game_ctrl_pkg.sv
// Shared definitions for the guessing-game controller: state codes, key bit
// positions, hint codes and small BCD helpers.
package guess_game_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ENTRY = 3'd1;
  localparam state_t ST_CHECK = 3'd2;
  localparam state_t ST_WIN   = 3'd3;
  localparam state_t ST_LOSE  = 3'd4;

  localparam int DIGIT0      = 0;
  localparam int DIGIT1      = 1;
  localparam int DIGIT2      = 2;
  localparam int DIGIT3      = 3;
  localparam int DIGIT4      = 4;
  localparam int DIGIT5      = 5;
  localparam int DIGIT6      = 6;
  localparam int DIGIT7      = 7;
  localparam int DIGIT8      = 8;
  localparam int DIGIT9      = 9;
  localparam int KEY_CLEAR   = 10;
  localparam int KEY_ENTER   = 11;
  localparam int KEY_NEWGAME = 15;

  localparam logic [1:0] HINT_NONE  = 2'b00;
  localparam logic [1:0] HINT_LOW   = 2'b01;
  localparam logic [1:0] HINT_HIGH  = 2'b10;
  localparam logic [1:0] HINT_EQUAL = 2'b11;

  localparam logic [11:0] LFSR_SEED = 12'hA5C;

  function automatic logic [3:0] onehot_to_digit(input logic [9:0] oh);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (oh[i]) d = 4'(i);
    end
    return d;
  endfunction

  function automatic logic [11:0] bcd_reduce(input logic [11:0] raw);
    logic [11:0] r;
    r = raw;
    for (int i = 0; i < 3; i++) begin
      if (raw[i*4 +: 4] > 4'd9) r[i*4 +: 4] = raw[i*4 +: 4] - 4'd10;
    end
    return r;
  endfunction

  // Walks least significant digit first so the most significant difference wins.
  function automatic logic [1:0] bcd_compare(input logic [11:0] g, input logic [11:0] t);
    logic [1:0] res;
    res = HINT_EQUAL;
    for (int i = 0; i < 3; i++) begin
      if (g[i*4 +: 4] < t[i*4 +: 4])      res = HINT_LOW;
      else if (g[i*4 +: 4] > t[i*4 +: 4]) res = HINT_HIGH;
    end
    return res;
  endfunction

endpackage

// File: rtl/guess_lfsr.sv
// Free-running 12-bit maximal-length LFSR used as the random target source;
// only present when GUESS_RANDOM_SECRET_EN is defined.
`ifdef GUESS_RANDOM_SECRET_EN
module guess_lfsr #(
  parameter logic [11:0] SEED = 12'hA5C
) (
  input  logic        clk,
  input  logic        RSTn,
  output logic [11:0] value
);

  // Taps 12,6,4,1: x^12 + x^6 + x^4 + x + 1.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) value <= SEED;
    else       value <= {value[10:0], value[11] ^ value[5] ^ value[3] ^ value[0]};
  end

endmodule
`endif

// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: keypad digit entry, BCD compare, win/lose.
// Define GUESS_RANDOM_SECRET_EN to draw each new target from a free-running LFSR.
module guess_game_ctrl
  import guess_game_ctrl_pkg::*;
#(
  parameter int          MAX_TRIES = 7,
  parameter logic [11:0] SECRET    = 12'h123
) (
  input  logic        clk,
  input  logic        RSTn,
  input  logic [15:0] key_deb,
  output logic [11:0] data,
  output logic [3:0]  tries,
  output logic [1:0]  hint,
  output logic        win,
  output logic        lose
);

  localparam logic [3:0] TRIES_LIMIT = 4'(MAX_TRIES);

  logic [15:0] key_r;
  logic [15:0] key_prev;
  logic [15:0] rise;
  logic        press_valid;
  logic        digit_press;
  logic        clear_press;
  logic        enter_press;
  logic        newgame_press;
  logic [3:0]  digit;

  state_t      state;
  logic [11:0] entry;
  logic [11:0] guess;
  logic [11:0] target;
  logic [11:0] next_target;
  logic [1:0]  count;
  logic [1:0]  cmp;

`ifdef GUESS_RANDOM_SECRET_EN
  localparam logic [11:0] RESET_TARGET = bcd_reduce(LFSR_SEED);

  logic [11:0] lfsr_value;

  guess_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .RSTn  (RSTn),
    .value (lfsr_value)
  );

  assign next_target = bcd_reduce(lfsr_value);
`else
  localparam logic [11:0] RESET_TARGET = SECRET;

  assign next_target = SECRET;
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      key_r    <= '0;
      key_prev <= '0;
    end else begin
      key_r    <= key_deb;
      key_prev <= key_r;
    end
  end

  // A press counts only when a single key rises while every other key is released.
  assign rise          = key_r & ~key_prev;
  assign press_valid   = (rise != '0) && ((rise & (rise - 16'd1)) == '0) && (key_r == rise);
  assign digit_press   = press_valid && (rise[DIGIT9:DIGIT0] != '0);
  assign clear_press   = press_valid && rise[KEY_CLEAR];
  assign enter_press   = press_valid && rise[KEY_ENTER];
  assign newgame_press = press_valid && rise[KEY_NEWGAME];
  assign digit         = onehot_to_digit(rise[DIGIT9:DIGIT0]);
  assign cmp           = bcd_compare(guess, target);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state  <= ST_IDLE;
      entry  <= '0;
      count  <= '0;
      guess  <= '0;
      tries  <= '0;
      hint   <= HINT_NONE;
      target <= RESET_TARGET;
    end else if (newgame_press) begin
      state  <= ST_IDLE;
      entry  <= '0;
      count  <= '0;
      tries  <= '0;
      hint   <= HINT_NONE;
      target <= next_target;
    end else begin
      case (state)
        ST_IDLE: begin
          if (digit_press) begin
            entry <= {8'h00, digit};
            count <= 2'd1;
            state <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (digit_press) begin
            hint <= HINT_NONE;
            if (count != 2'd3) begin
              entry <= {entry[7:0], digit};
              count <= count + 2'd1;
            end
          end else if (clear_press) begin
            entry <= '0;
            count <= '0;
          end else if (enter_press && (count != 2'd0)) begin
            guess <= entry;
            tries <= (tries == TRIES_LIMIT) ? tries : tries + 4'd1;
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          hint <= cmp;
          if (cmp == HINT_EQUAL) begin
            state <= ST_WIN;
          end else if (tries == TRIES_LIMIT) begin
            state <= ST_LOSE;
          end else begin
            entry <= '0;
            count <= '0;
            state <= ST_ENTRY;
          end
        end
        ST_WIN, ST_LOSE: begin
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    data = entry;
    case (state)
      ST_CHECK:        data = guess;
      ST_WIN, ST_LOSE: data = target;
      default:         data = entry;
    endcase
  end

  assign win  = (state == ST_WIN);
  assign lose = (state == ST_LOSE);

endmodule

// File: doc/guess_game_ctrl.md
GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 7, the number of guesses allowed before a loss (1..15).
REQ-002 SHALL have parameter SECRET, default 12'h123, the fixed 3-digit BCD target used when the random target is not compiled in.
REQ-003 SHALL have port clk, input, 1, system clock (50 MHz); one clock only.
REQ-004 SHALL have port RSTn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port key_deb, input, 16, debounced one-hot key levels: bits 0-9 are digits 0-9, bit 10 is CLEAR, bit 11 is ENTER, bit 15 is NEW_GAME, and bits 12-14 are unused.
REQ-006 SHALL have port data, output, 12, three BCD digits for the display.
REQ-007 SHALL have port tries, output, 4, the number of guesses consumed.
REQ-008 SHALL have port hint, output, 2, where 00 means none, 01 means guess too low, 10 means guess too high, and 11 means equal.
REQ-009 SHALL have port win, output, 1, a level asserted in state WIN.
REQ-010 SHALL have port lose, output, 1, a level asserted in state LOSE.

Function
REQ-011 SHALL register key_deb once and derive press events on 0->1 transitions; a press is valid only if exactly one bit rises and no other bit is high; otherwise it SHALL be ignored.
REQ-012 SHALL implement states IDLE, ENTRY, CHECK, WIN and LOSE.
REQ-013 IDLE: any valid digit press SHALL load that digit, set count=1, and go to ENTRY; ENTER and CLEAR SHALL be ignored.
REQ-014 ENTRY digit press: if count<3, SHALL shift entry left 4 bits, insert the digit in [3:0], and increment count; at count=3 the press SHALL be ignored (no wrap).
REQ-015 ENTRY CLEAR: SHALL set entry=0 and count=0 and remain in ENTRY.
REQ-016 ENTRY ENTER: with count=0 SHALL be ignored; otherwise SHALL latch guess=entry, increment tries, and go to CHECK.
REQ-017 CHECK SHALL last exactly one cycle and compare guess to target digit-wise, most significant digit first.
REQ-018 On equal, CHECK SHALL set hint=11 and go to WIN.
REQ-019 On not equal with tries==MAX_TRIES, CHECK SHALL set the too-low or too-high hint and go to LOSE.
REQ-020 Otherwise, CHECK SHALL set hint to 01 or 10, clear entry and count, and return to ENTRY.
REQ-021 The hint SHALL hold until the next digit press in ENTRY, which SHALL clear it to 00.
REQ-022 data SHALL show entry in IDLE and ENTRY, guess in CHECK, and target in WIN and LOSE.
REQ-023 WIN and LOSE SHALL ignore all keys except NEW_GAME.
REQ-024 NEW_GAME in any state SHALL return to IDLE with entry, count, tries and hint cleared, and SHALL select a new target.
REQ-025 Latency SHALL be: press event at edge N, state and outputs updated at edge N+1, hint valid at edge N+2 after ENTER.
REQ-026 tries SHALL saturate at MAX_TRIES.
REQ-027 A digit press and NEW_GAME rising in the same cycle SHALL be treated as an invalid press and ignored.

Reset
REQ-028 Asserting RSTn low SHALL asynchronously force IDLE, data=0, tries=0, hint=00, win=0, lose=0, entry=0, count=0, and target=SECRET (or the LFSR seed value when the random target is compiled in).
REQ-029 Reset asserted mid-guess SHALL discard all progress; the first valid press after release SHALL be processed normally.

Configuration
REQ-030 With macro GUESS_RANDOM_SECRET_EN defined, a free-running LFSR clocked by clk SHALL run, and NEW_GAME SHALL sample it into a valid BCD target, reducing each nibble modulo 10.
REQ-031 Without GUESS_RANDOM_SECRET_EN, the target SHALL always be SECRET and no LFSR logic SHALL exist.

Structure
REQ-032 A shared package SHALL hold the state enum, the key bit indices (DIGIT0..9, KEY_CLEAR=10, KEY_ENTER=11, KEY_NEWGAME=15) and the hint codes.
REQ-033 The LFSR SHALL be a sub-module named guess_lfsr, instantiated only under GUESS_RANDOM_SECRET_EN.

Verification
REQ-034 Scenario: target 123; press 1,2,3,ENTER -> data=12'h123, hint=11, win=1, tries=1.
REQ-035 Scenario: target 123; press 4,5,6,ENTER -> hint=10, tries=1; then press 1 -> hint=00, data=12'h001.
REQ-036 Scenario: MAX_TRIES=2, target 123; enter 100 then 200 -> lose=1, hint=10, data=12'h123; a subsequent ENTER causes no change.
REQ-037 Scenario: press 9,8,7,6 -> data=12'h987; press CLEAR -> data=0; ENTER -> no state change, tries=0.
REQ-038 Scenario: bits 3 and 5 rise together -> no change; holding a key high for 1000 cycles -> exactly one digit entered.
REQ-039 Scenario: RSTn low during ENTRY with tries=3 -> all outputs return to reset values asynchronously within the reset cycle; NEW_GAME from WIN -> IDLE, tries=0.
